// File: rtl/rst_seq_pkg.sv
// Shared definitions for the staged reset-release sequencer.
// Holds the FSM state encoding and a small helper for sizing counters.
package rst_seq_pkg;

    localparam int ST_W = 2;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_HOLD    = 2'd0;
    localparam state_t ST_RELEASE = 2'd1;
    localparam state_t ST_DONE    = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sig_sync.sv
// N-flop synchronizer for a single asynchronous level signal.
// An async clear forces every flop low, so the input reads as low during reset.
module sig_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/rst_seq.sv
// Staged reset-release sequencer: qualifies lock, then releases NUM_STAGE
// active-low resets one at a time, STAGE_DLY cycles apart.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HOLD    | all outputs held in reset, filtering synchronized lock
// RELEASE | releasing stages in ascending order, one per STAGE_DLY
// DONE    | every stage released, done_o high
// (3)     | unused encoding, recovers to HOLD
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGE   = 4,
    parameter int STAGE_DLY   = 16,
    parameter int LOCK_FILT   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lock_i,
    input  logic                 sw_rst_i,
    output logic [NUM_STAGE-1:0] rst_n_o,
    output logic                 done_o,
    output logic [ST_W-1:0]      state_o
);

    localparam int CNT_W = $clog2(max_int(LOCK_FILT, STAGE_DLY) + 1);
    localparam int IDX_W = $clog2(NUM_STAGE + 1);

    localparam logic [CNT_W-1:0]     LOCK_LAST  = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0]     STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_STAGE - 1);
    localparam logic [NUM_STAGE-1:0] STAGE_ONE  = NUM_STAGE'(1);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nxt;
    logic [NUM_STAGE-1:0] rst_nxt;
    logic                 done_nxt;
    logic                 lock_s;
    logic                 abort;

    sig_sync #(
        .N (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (lock_i),
        .q     (lock_s)
    );

    assign abort = !lock_s || sw_rst_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_HOLD;
            cnt     <= '0;
            idx     <= '0;
            rst_n_o <= '0;
            done_o  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            rst_n_o <= rst_nxt;
            done_o  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HOLD: begin
                if (!abort && cnt == LOCK_LAST) state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (abort) begin
                    state_nxt = ST_HOLD;
                end else if (cnt == STAGE_LAST && idx == IDX_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (abort) state_nxt = ST_HOLD;
            end
            default: state_nxt = ST_HOLD;
        endcase
    end

    // Abort takes priority over every normal transition and clears the datapath.
    always_comb begin
        cnt_nxt  = cnt;
        idx_nxt  = idx;
        rst_nxt  = rst_n_o;
        done_nxt = done_o;
        if (abort) begin
            cnt_nxt  = '0;
            idx_nxt  = '0;
            rst_nxt  = '0;
            done_nxt = 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    rst_nxt  = '0;
                    done_nxt = 1'b0;
                    if (cnt == LOCK_LAST) begin
                        cnt_nxt = '0;
                        idx_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt == STAGE_LAST) begin
                        cnt_nxt = '0;
                        idx_nxt = idx + IDX_W'(1);
                        rst_nxt = rst_n_o | (STAGE_ONE << idx);
                        if (idx == IDX_LAST) done_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    cnt_nxt  = '0;
                    rst_nxt  = '1;
                    done_nxt = 1'b1;
                end
                default: begin
                    cnt_nxt  = '0;
                    idx_nxt  = '0;
                    rst_nxt  = '0;
                    done_nxt = 1'b0;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule
